seq_bit_serializer: RTL and testbench
=====================================

# seq_bit_serializer

Parallel-to-serial bit source that sits directly upstream of the team's Moore sequence detector and drives its single-bit `in` port with one bit per clock. It accepts WIDTH-bit words over a valid/ready handshake and double-buffers them in a holding register plus a shift register, so back-to-back words stream with no idle gap. Between words it drives a constant idle level, which the detector sees as ordinary input.

## Interface
- WIDTH, 8: word size in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0: level driven on `out` when no word is being shifted.

- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  WIDTH  word to serialize; sampled on accept.
- load_valid  input  1  producer offers data_in this cycle.
- load_ready  output  1  holding register empty; accept = load_valid & load_ready.
- out  output  1  serial bit stream, connects to detector `in`.
- busy  output  1  shift register holds a word being shifted.
- first  output  1  high on the cycle `out` carries bit 0 of a word's transmit order.
- last  output  1  high on the cycle `out` carries the final bit of a word.

## Operation
- Storage: hold_reg[WIDTH] + hold_full; shift_reg[WIDTH]; bit_cnt[$clog2(WIDTH)]; 2-state FSM IDLE/SHIFT (busy = state==SHIFT).
- Accept: at a clock edge with load_valid & load_ready, data_in is written to hold_reg and hold_full is set.
- load_ready = !hold_full && !reset. It is derived from registers plus reset only, with no path from load_valid.
- Transfer hold -> shift: occurs at an edge where hold_full=1 and either (state==IDLE) or (state==SHIFT and bit_cnt==WIDTH-1). On transfer:
  - shift_reg gets hold_reg, bit_cnt gets 0, state goes to SHIFT, hold_full clears.
  - If an accept happens at the same edge, the new word overwrites hold_reg and hold_full stays 1. This cannot happen in practice because load_ready=0 whenever hold_full=1; the rule is stated for completeness.
- Shift: in SHIFT with bit_cnt<WIDTH-1, each edge shifts shift_reg by one position toward the output end and increments bit_cnt.
- End of word: in SHIFT with bit_cnt==WIDTH-1 and hold_full=0, the next edge moves the FSM to IDLE.
- out = (state==SHIFT) ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_BIT.
- first = (state==SHIFT) && bit_cnt==0.
- last = (state==SHIFT) && bit_cnt==WIDTH-1.
- Words are never dropped or reordered, and no bit is repeated.

## Timing
- Reset values (asserted asynchronously, held while reset=1):
  - state = IDLE, hold_full = 0, bit_cnt = 0, shift_reg = 0, hold_reg = 0.
  - out = IDLE_BIT, busy = 0, first = 0, last = 0, load_ready = 0.
  - load_ready rises in the first cycle after reset deasserts.
- Latency from an idle start:
  - Word accepted at edge E0 is in hold at E0+1 cycle.
  - It transfers at edge E1.
  - Its first bit is on `out` in the cycle after E1, i.e. 2 cycles after the accept edge.
  - Its last bit appears WIDTH-1 cycles after its first bit.
- Streaming: if hold_full=1 during a word's last-bit cycle, the next word's first bit appears in the immediately following cycle. `first` follows `last` with no gap.
- Throughput: load_ready re-asserts the cycle after each transfer. With WIDTH>=2, a producer that answers ready within WIDTH-1 cycles sustains 100% line utilization.
- Reset mid-word: the word in shift_reg and any held word are discarded, and `out` returns to IDLE_BIT in the same cycle reset asserts. No partial bits continue after reset releases.
- load_valid while load_ready=0: ignored. The producer must hold data_in and load_valid stable until accept.

## Test plan
- Idle and reset: reset asserted then released with load_valid=0 for 20 cycles.
  - out=IDLE_BIT, busy/first/last=0 throughout.
  - load_ready=0 during reset and 1 afterward.
- Single word: WIDTH=8, MSB_FIRST=1, accept 8'hD0 at edge 0.
  - out = 1,1,0,1,0,0,0,0 in cycles 2..9, first in cycle 2, last in cycle 9.
  - out=0 and busy=0 from cycle 10.
  - The downstream detector sees 1101 once.
- Back-to-back with backpressure: load_valid held high with words A=8'hD0, B=8'hD5, C=8'h0D.
  - A accepted at edge 0, B at edge 2, C at edge 10.
  - Bits of A in cycles 2..9, B in 10..17, C in 18..25, with no gaps.
  - load_ready is 0 in cycles 3..9 and 11..17.
- LSB-first: MSB_FIRST=0, accept 8'h0B.
  - out = 1,1,0,1,0,0,0,0 in cycles 2..9.
- Reset mid-operation: accept 8'hFF and 8'hAA back-to-back, assert reset in cycle 5 for 2 cycles.
  - out=IDLE_BIT immediately on reset.
  - No further bits of either word appear; hold_full=0 and load_ready=1 after release.
  - A fresh word accepted afterward follows the single-word timing.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word load handshake plus serial bit stream toward the detector.
interface seq_bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             out;
   logic             busy;
   logic             first;
   logic             last;
   modport master (
      output data_in, load_valid,
      input  load_ready, out, busy, first, last
   );
   modport slave (
      input  data_in, load_valid,
      output load_ready, out, busy, first, last
   );
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: double-buffered parallel-to-serial bit source, one bit per clock.
module seq_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   seq_bit_serializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d, shift_q, shift_d, shifted;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept, last_bit, shifting, xfer;
   assign bus.load_ready = ~hold_full_q & ~reset;
   assign accept         = bus.load_valid & bus.load_ready;
   assign last_bit       = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign shifting       = (state_q == SHIFT) && !last_bit;
   // the held word moves in when the shifter is empty or is on its final bit
   assign xfer           = hold_full_q && ((state_q == IDLE) || last_bit);
   assign shifted        = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
   always_comb begin
      hold_d      = accept ? bus.data_in : hold_q;
      hold_full_d = accept | (hold_full_q & ~xfer);
      state_d     = xfer ? SHIFT : (last_bit ? IDLE : state_q);
      cnt_d       = xfer ? '0 : (shifting ? cnt_q + CW'(1) : cnt_q);
      shift_d     = xfer ? hold_q : (shifting ? shifted : shift_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
      end
   end
   assign bus.busy  = (state_q == SHIFT);
   assign bus.out   = bus.busy ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;
   assign bus.first = bus.busy && (cnt_q == '0);
   assign bus.last  = last_bit;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed checks of an MSB-first and an LSB-first serializer.
module tb_seq_bit_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   seq_bit_serializer_if #(.WIDTH(8)) bm ();
   seq_bit_serializer_if #(.WIDTH(8)) bl ();
   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset(reset), .bus(bm)
   );
   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .bus(bl)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   // cycle c is the interval ending at rising edge c; it is sampled on the preceding falling edge
   task automatic run_single(input logic [7:0] wm, input logic [7:0] wl);
      logic [7:0] exp_bits;
      logic [3:0] win_m, win_l;
      int hits_m, hits_l;
      logic eo;
      exp_bits = 8'b1101_0000;
      win_m = '0; win_l = '0; hits_m = 0; hits_l = 0;
      @(negedge clk);
      bm.data_in = wm; bl.data_in = wl;
      bm.load_valid = 1'b1; bl.load_valid = 1'b1;
      chk("single_ready0", bm.load_ready, 1);
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) begin
            bm.load_valid = 1'b0; bl.load_valid = 1'b0;
         end
         eo = (c >= 2 && c <= 9) ? exp_bits[9-c] : 1'b0;
         chk($sformatf("single_out_m_c%0d", c), bm.out, eo);
         chk($sformatf("single_out_l_c%0d", c), bl.out, eo);
         chk($sformatf("single_first_c%0d", c), bm.first, c == 2);
         chk($sformatf("single_last_c%0d", c), bm.last, c == 9);
         chk($sformatf("single_busy_c%0d", c), bm.busy, c >= 2 && c <= 9);
         chk($sformatf("single_lfirst_c%0d", c), bl.first, c == 2);
         chk($sformatf("single_llast_c%0d", c), bl.last, c == 9);
         if (c >= 1) chk($sformatf("single_ready_c%0d", c), bm.load_ready, c != 1);
         win_m = {win_m[2:0], bm.out};
         win_l = {win_l[2:0], bl.out};
         if (win_m == 4'b1101) hits_m++;
         if (win_l == 4'b1101) hits_l++;
      end
      chk("single_detect_m", hits_m, 1);
      chk("single_detect_l", hits_l, 1);
   endtask
   task automatic run_stream();
      logic [23:0] s;
      logic [7:0] w [3];
      int acc [3];
      int n;
      s = 24'hD0D50D;
      w[0] = 8'hD0; w[1] = 8'hD5; w[2] = 8'h0D;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      n = 0;
      @(negedge clk);
      bm.data_in = w[0]; bm.load_valid = 1'b1;
      for (int c = 0; c <= 27; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("stream_out_c%0d", c), bm.out, (c >= 2 && c <= 25) ? s[25-c] : 1'b0);
         chk($sformatf("stream_first_c%0d", c), bm.first, c == 2 || c == 10 || c == 18);
         chk($sformatf("stream_last_c%0d", c), bm.last, c == 9 || c == 17 || c == 25);
         chk($sformatf("stream_busy_c%0d", c), bm.busy, c >= 2 && c <= 25);
         if (c >= 1 && c <= 18)
            chk($sformatf("stream_ready_c%0d", c), bm.load_ready, c == 2 || c == 10 || c == 18);
         if (bm.load_valid && bm.load_ready && n < 3) begin
            acc[n] = c;
            n++;
            @(posedge clk);
            #1;
            if (n < 3) bm.data_in = w[n];
            else bm.load_valid = 1'b0;
         end
      end
      chk("stream_accepts", n, 3);
      chk("stream_acc_a", acc[0], 0);
      chk("stream_acc_b", acc[1], 2);
      chk("stream_acc_c", acc[2], 10);
   endtask
   task automatic run_reset();
      int n;
      n = 0;
      @(negedge clk);
      bm.data_in = 8'hFF; bm.load_valid = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) @(negedge clk);
         if (c >= 2) begin
            chk($sformatf("rstmid_out_c%0d", c), bm.out, 1);
            chk($sformatf("rstmid_busy_c%0d", c), bm.busy, 1);
         end
         if (bm.load_valid && bm.load_ready && n < 2) begin
            n++;
            @(posedge clk);
            #1;
            if (n == 1) bm.data_in = 8'hAA;
            else bm.load_valid = 1'b0;
         end
      end
      chk("rstmid_accepts", n, 2);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rstmid_out_now", bm.out, 0);
      chk("rstmid_busy_now", bm.busy, 0);
      chk("rstmid_first_now", bm.first, 0);
      chk("rstmid_last_now", bm.last, 0);
      chk("rstmid_ready_now", bm.load_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("rstmid_ready_rel", bm.load_ready, 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("rstmid_quiet_out_c%0d", c), bm.out, 0);
         chk($sformatf("rstmid_quiet_busy_c%0d", c), bm.busy, 0);
         chk($sformatf("rstmid_quiet_ready_c%0d", c), bm.load_ready, 1);
      end
   endtask
   initial begin
      bm.data_in = '0; bm.load_valid = 1'b0;
      bl.data_in = '0; bl.load_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("reset_ready", bm.load_ready, 0);
         chk("reset_out", bm.out, 0);
         chk("reset_busy", bm.busy, 0);
         chk("reset_first", bm.first, 0);
         chk("reset_last", bm.last, 0);
         chk("reset_lout", bl.out, 0);
      end
      reset = 1'b0;
      #1 chk("release_ready", bm.load_ready, 1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_ready", bm.load_ready, 1);
         chk("idle_out", bm.out, 0);
         chk("idle_busy", bm.busy, 0);
         chk("idle_first", bm.first, 0);
         chk("idle_last", bm.last, 0);
         chk("idle_lout", bl.out, 0);
      end
      run_single(8'hD0, 8'h0B);
      run_stream();
      run_reset();
      run_single(8'hD0, 8'h0B);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
